// File: rtl/ccff_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader_if
// Description : Host-side bitstream handshake and chain-side outputs of the
//               configuration-chain loader.
// Revision    : 1.0
// ============================================================================
interface ccff_loader_if #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [15:0]       crc_expected;
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              busy;
   logic              done;
   logic              crc_err;
   logic [CNT_W-1:0]  bit_cnt;

   modport master (
      output start, crc_expected, cfg_data, cfg_valid,
      input  cfg_ready, ccff_head, ccff_shift_en, busy, done, crc_err, bit_cnt
   );

   modport slave (
      input  start, crc_expected, cfg_data, cfg_valid,
      output cfg_ready, ccff_head, ccff_shift_en, busy, done, crc_err, bit_cnt
   );
endinterface
`default_nettype wire

// File: rtl/ccff_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_loader
// Description : Serialises bitstream words MSB-first onto the ccff chain head
//               and checks a CRC-16-CCITT over the shifted bits.
// Revision    : 1.0
// ============================================================================
module ccff_loader #(
   parameter int CHAIN_LEN = 1024,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic         prog_clk,
   input  logic         pReset,
   ccff_loader_if.slave bus
);
   localparam int              SC_W       = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(CHAIN_LEN - 1);
   localparam logic [SC_W-1:0]  c_full     = SC_W'(WORD_W);
   localparam logic [SC_W-1:0]  c_one      = SC_W'(1);
   localparam logic [15:0]      c_crc_poly = 16'h1021;
   localparam logic [15:0]      c_crc_init = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [WORD_W-1:0] r_sreg;
   logic [SC_W-1:0]   r_sreg_cnt;
   logic              r_last_head;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [15:0]       r_crc;
   logic [15:0]       r_crc_exp;
   logic              r_crc_err;

   logic              w_ready;
   logic              w_shift;
   logic              w_last;
   logic              w_start_load;
   logic              w_accept;
   logic              w_head;
   logic              w_fb;
   logic [15:0]       w_crc_next;

   // r_sreg_cnt counts the bits not yet shifted, including the one on the head
   assign w_head     = (r_sreg_cnt != '0) ? r_sreg[WORD_W-1] : r_last_head;
   assign w_fb       = r_crc[15] ^ w_head;
   assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? c_crc_poly : 16'h0000);
   assign w_accept   = bus.cfg_valid & w_ready;

   always_ff @(posedge prog_clk) begin
      if (pReset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_ready      = 1'b0;
      w_shift      = 1'b0;
      w_last       = 1'b0;
      w_start_load = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_start_load = 1'b1;
               w_next_state = LOAD;
            end
         end
         LOAD: begin
            w_shift = (r_sreg_cnt != '0);
            w_last  = w_shift && (r_bit_cnt == c_last_bit);
            // no new word once the final chain bit is on the head
            w_ready = (r_sreg_cnt == '0) ||
                      ((r_sreg_cnt == c_one) && (r_bit_cnt != c_last_bit));
            if (w_last) w_next_state = CHECK;
         end
         CHECK:   w_next_state = DONE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_sreg      <= '0;
         r_sreg_cnt  <= '0;
         r_last_head <= 1'b0;
         r_bit_cnt   <= '0;
         r_crc       <= '0;
         r_crc_exp   <= '0;
         r_crc_err   <= 1'b0;
      end else begin
         if (w_start_load) begin
            r_crc_exp  <= bus.crc_expected;
            r_bit_cnt  <= '0;
            r_crc      <= c_crc_init;
            r_sreg_cnt <= '0;
            r_crc_err  <= 1'b0;
         end
         if (w_shift) begin
            r_sreg      <= r_sreg << 1;
            r_sreg_cnt  <= w_last ? '0 : (r_sreg_cnt - c_one);
            r_last_head <= w_head;
            r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
            r_crc       <= w_crc_next;
         end
         // a refill on the last buffered bit overrides the shift bookkeeping
         if (w_accept) begin
            r_sreg     <= bus.cfg_data;
            r_sreg_cnt <= c_full;
         end
         if (r_state == CHECK) r_crc_err <= (r_crc != r_crc_exp);
      end
   end

   assign bus.cfg_ready     = w_ready;
   assign bus.ccff_head     = w_head;
   assign bus.ccff_shift_en = w_shift;
   assign bus.busy          = (r_state == LOAD) || (r_state == CHECK);
   assign bus.done          = (r_state == DONE);
   assign bus.crc_err       = r_crc_err;
   assign bus.bit_cnt       = r_bit_cnt;
endmodule
`default_nettype wire

// File: doc/ccff_loader.md
Name: ccff_loader

Overview:
- Configuration-chain loader for the FPGA fabric.
- Accepts bitstream words from the host/bring-up interface over a valid/ready handshake and serialises them, MSB-first, onto the fabric's configuration flip-flop chain head (ccff_head of the first tile).
- Emits a per-bit shift enable used to gate the chain clock.
- Computes a CRC-16 over the shifted bits and flags a mismatch against the host-supplied expected value.

Parameters:
- CHAIN_LEN, 1024: total configuration bits in the chain (≥1); exactly this many bits are shifted per load.
- WORD_W, 8: bitstream word width (≥1).
- CNT_W, 16: bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when in IDLE.
- crc_expected  in  16  expected CRC; sampled on the accepted start cycle.
- cfg_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts the word this cycle (valid & ready).
- ccff_head  out  1  serial bit to chain head.
- ccff_shift_en  out  1  chain advances one position at the end of this cycle.
- busy  out  1  high in LOAD or CHECK.
- done  out  1  high in DONE.
- crc_err  out  1  CRC mismatch of the last load; valid while done=1.
- bit_cnt  out  CNT_W  bits shifted so far in the current or last load.

Behaviour:
- Reset (pReset=1 at clock edge):
  - state=IDLE; all outputs 0; shift register, bit counter and CRC cleared.
  - Reset mid-load aborts immediately and ccff_shift_en drops the next cycle. Chain content is then undefined and a full reload is required.
- States: IDLE, LOAD, CHECK, DONE.
- IDLE:
  - cfg_ready=0, ccff_shift_en=0.
  - start=1 -> LOAD. Latch crc_expected, bit_cnt:=0, CRC:=0xFFFF.
- LOAD:
  - Shift register holds 0..WORD_W bits. cfg_ready=1 when it is empty, or holds exactly 1 bit that is being shifted this cycle. This gives gap-free streaming of back-to-back words.
  - A word accepted at cycle t presents its MSB on ccff_head with ccff_shift_en=1 at cycle t+1.
  - Each shift cycle: ccff_shift_en=1, bit_cnt+=1, and the CRC is updated with ccff_head.
  - CRC: CRC-16-CCITT, poly 0x1021, MSB-first, no reflection, no final XOR.
  - Starvation: shift register empty and no word -> ccff_shift_en=0, ccff_head holds its last value, bit_cnt unchanged.
  - When bit_cnt reaches CHAIN_LEN (last shift cycle): -> CHECK next cycle. cfg_ready=0 from then on.
  - Surplus bits of a partial last word (CHAIN_LEN not a multiple of WORD_W) are discarded: not shifted, not CRC'd.
  - start while busy is ignored.
- CHECK (1 cycle): crc_err := (CRC != latched crc_expected); -> DONE.
- DONE:
  - done=1; crc_err and bit_cnt held.
  - start=1 -> LOAD: same action as from IDLE; done and crc_err clear next cycle.
- Derived outputs:
  - busy = (state==LOAD || state==CHECK).
  - ccff_shift_en is never high outside LOAD.
  - Exactly CHAIN_LEN shift-enable cycles occur per completed load.
- Simultaneous events:
  - pReset has priority over start.
  - cfg_valid outside LOAD is not accepted: ready=0, data unconsumed.

Test Plan:
- Golden CRC: CHAIN_LEN=72, WORD_W=8, crc_expected=0x29B1. Stream bytes 0x31..0x39 back-to-back with valid held high -> 72 consecutive ccff_shift_en cycles; head sequence equals the bits of "123456789" MSB-first; crc_err=0; done=1 two cycles after the last shift; bit_cnt=72.
- Mismatch: same stream, crc_expected=0x29B0 -> crc_err=1, done=1.
- Partial word: CHAIN_LEN=10, WORD_W=8, words 0xA5, 0xC0 -> head 1,0,1,0,0,1,0,1,1,1; exactly 10 shift cycles; the remaining 6 bits of 0xC0 are never shifted.
- Starvation: valid gaps of 3 cycles between words -> ccff_shift_en=0 and ccff_head stable during gaps; total shift cycles still equals CHAIN_LEN.
- Reset mid-load: assert pReset after 20 of 72 bits -> next cycle all outputs 0, state IDLE. A subsequent start and full stream completes with crc_err=0 and bit_cnt=72.
- Start handling: start pulses during LOAD have no effect. Start in DONE clears done next cycle and reloads; cfg_ready stays 0 in IDLE/CHECK/DONE even with cfg_valid=1.
